aht10_i2c_responder: RTL and testbench
======================================

AHT10_I2C_RESPONDER -- requirements
Module: aht10_i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h38, the 7-bit I2C address it answers to.
REQ-002 SHALL have parameter RD_BYTES, default 6, the number of frame bytes returned per read transfer.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port scl, input, 1, the I2C clock from the master; asynchronous.
REQ-006 SHALL have port sda_i, input, 1, the sampled SDA line; asynchronous.
REQ-007 SHALL have port sda_oe, output, 1, open-drain pull-down: 1 drives SDA low, 0 releases it.
REQ-008 SHALL have port rd_frame, input, 8*RD_BYTES, the sensor frame, byte 0 in the MSBs (status, humidity, temperature).
REQ-009 SHALL have port wr_data, output, 8, the last byte written by the master.
REQ-010 SHALL have port wr_valid, output, 1, a one-clk pulse per accepted write data byte.
REQ-011 SHALL have port wr_first, output, 1, asserted with wr_valid when the byte is the first after the address (the command byte).
REQ-012 SHALL have port rd_start, output, 1, a one-clk pulse when a read address is ACKed; rd_frame is latched on that cycle.
REQ-013 SHALL have port bus_stop, output, 1, a one-clk pulse on every detected STOP.

Function
REQ-014 SHALL pass scl and sda_i through 2-FF synchronizers and detect edges on the synchronized copies; detection latency is 3 clk.
REQ-015 SHALL detect START (SDA falling while SCL high) in any state and go to ADDR with the bit counter cleared; this also covers repeated START.
REQ-016 SHALL detect STOP (SDA rising while SCL high) in any state, go to IDLE, release sda_oe and pulse bus_stop.
REQ-017 SHALL use the FSM states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK and WAIT_STOP.
REQ-018 SHALL sample SDA on SCL rising edges MSB first, and SHALL change sda_oe only on SCL falling edges.
REQ-019 ADDR SHALL collect 8 bits; on a match it goes to ADDR_ACK and drives ACK; on a mismatch it goes to WAIT_STOP with SDA released.
REQ-020 After the ACK bit, R/W=0 SHALL go to WR_BYTE and R/W=1 SHALL go to RD_BYTE and pulse rd_start.
REQ-021 WR_BYTE SHALL, after 8 bits, update wr_data, pulse wr_valid, ACK in WR_ACK, then return to WR_BYTE; every write byte is ACKed.
REQ-022 RD_BYTE SHALL drive byte index k of the latched frame, pulling SDA low for 0 bits and releasing it for 1 bits.
REQ-023 For k >= RD_BYTES the read SHALL return 8'hFF; the index saturates and does not wrap.
REQ-024 RD_ACK SHALL release SDA and sample the master's bit: ACK (0) increments k and returns to RD_BYTE; NACK (1) goes to WAIT_STOP.
REQ-025 WAIT_STOP SHALL keep SDA released and leave only on STOP or START.
REQ-026 If START and STOP would both be detected on the same clk, STOP SHALL be acted on first (they cannot coincide on a legal bus).
REQ-027 A change of rd_frame during a read SHALL not affect the transfer in progress.

Reset
REQ-028 While rst is high the block SHALL set the state to IDLE and sda_oe, wr_valid, wr_first, rd_start and bus_stop to 0.
REQ-029 While rst is high the block SHALL clear wr_data, the latched frame, the bit counter and k, and set the synchronizers to 1 (idle bus).
REQ-030 A reset asserted mid-transfer SHALL release SDA on the next clk; after reset the block ignores bus activity until the next START.

Structure
REQ-031 The FSM state encoding and the AHT10 command constants (8'hE1 init, 8'hAC trigger, 8'hBA soft reset) SHALL live in a shared package, aht10_pkg.
REQ-032 The synchronizer plus START/STOP/edge detector SHALL be one sub-module, i2c_bus_sync, with outputs scl_rise, scl_fall, sda_s, start_det and stop_det.

Verification
REQ-033 Write 0x70, 0xAC, 0x33, 0x00 then STOP -> address ACKed; wr_valid pulses 3 times with wr_data 0xAC (wr_first=1), 0x33, 0x00; bus_stop pulses once.
REQ-034 rd_frame=48'h1C_6B_A5_35_F2_10, read 0x71, 6 bytes ACK/ACK/.../NACK -> master sees 1C 6B A5 35 F2 10; state is WAIT_STOP until STOP.
REQ-035 Address 0x72 (wrong device) -> SDA never driven for the rest of the transfer; no wr_valid or rd_start.
REQ-036 Read 8 bytes with all ACKs -> bytes 7 and 8 are 0xFF.
REQ-037 Write 0x70, 0xE1, then repeated START and read 0x71 -> wr_valid with 0xE1, then rd_start, then correct byte 0.
REQ-038 rst pulsed during read byte 2 while driving a 0 -> sda_oe=0 on the next clk; the next transfer completes normally.

Source files
------------

// File: rtl/aht10_pkg.sv
// aht10_pkg: responder FSM state encoding and AHT10 command bytes
package aht10_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [7:0] CMD_INIT = 8'hE1;
  localparam logic [7:0] CMD_TRIG = 8'hAC;
  localparam logic [7:0] CMD_SRST = 8'hBA;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronizers plus registered SCL edge and START/STOP detection
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // stages [1:0] synchronize, stage [2] is the previous value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      sda_s     <= 1'b1;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= {scl_q[1:0], scl};
      sda_q     <= {sda_q[1:0], sda_i};
      scl_rise  <= scl_q[1] & ~scl_q[2];
      scl_fall  <= ~scl_q[1] & scl_q[2];
      sda_s     <= sda_q[1];
      start_det <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
      stop_det  <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end
  end

endmodule

// File: rtl/aht10_i2c_responder.sv
// aht10_i2c_responder: I2C target answering reads with a latched sensor frame and reporting written bytes
module aht10_i2c_responder
  import aht10_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h38,
  parameter int         RD_BYTES = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl,
  input  logic                    sda_i,
  output logic                    sda_oe,
  input  logic [8*RD_BYTES-1:0]   rd_frame,
  output logic [7:0]              wr_data,
  output logic                    wr_valid,
  output logic                    wr_first,
  output logic                    rd_start,
  output logic                    bus_stop
);

  localparam int KW = $clog2(RD_BYTES + 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [7:0]            sh, sh_n;
  logic [KW-1:0]         k, k_n;
  logic [8*RD_BYTES-1:0] frame, frame_n;
  logic                  oe_n, first, first_n;
  logic [7:0]            wr_data_n, cur;
  logic                  wr_valid_n, wr_first_n, rd_start_n, bus_stop_n;

  // byte currently being read; past the end of the frame the bus idles high
  always_comb cur = (k >= KW'(RD_BYTES)) ? 8'hFF : 8'(frame >> (8 * (RD_BYTES - 1 - int'(k))));

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      k        <= '0;
      frame    <= '0;
      sda_oe   <= 1'b0;
      first    <= 1'b0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      wr_first <= 1'b0;
      rd_start <= 1'b0;
      bus_stop <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      k        <= k_n;
      frame    <= frame_n;
      sda_oe   <= oe_n;
      first    <= first_n;
      wr_data  <= wr_data_n;
      wr_valid <= wr_valid_n;
      wr_first <= wr_first_n;
      rd_start <= rd_start_n;
      bus_stop <= bus_stop_n;
    end
  end

  // next-state logic; STOP outranks START, and both outrank bit-level activity
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    k_n        = k;
    frame_n    = frame;
    oe_n       = sda_oe;
    first_n    = first;
    wr_data_n  = wr_data;
    wr_valid_n = 1'b0;
    wr_first_n = 1'b0;
    rd_start_n = 1'b0;
    bus_stop_n = 1'b0;
    if (stop_det) begin
      state_n    = IDLE;
      oe_n       = 1'b0;
      bus_stop_n = 1'b1;
    end else if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) state_n = (sh[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
        end
        // first fall after the address drives ACK, the next one ends it
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe) oe_n = 1'b1;
          else if (sh[0]) begin
            state_n    = RD_BYTE;
            cnt_n      = '0;
            k_n        = '0;
            frame_n    = rd_frame;
            rd_start_n = 1'b1;
            oe_n       = ~rd_frame[8*RD_BYTES-1];
          end else begin
            state_n = WR_BYTE;
            cnt_n   = '0;
            first_n = 1'b1;
            oe_n    = 1'b0;
          end
        end
        WR_BYTE: if (scl_rise) begin
          sh_n  = {sh[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            state_n    = WR_ACK;
            wr_data_n  = sh_n;
            wr_valid_n = 1'b1;
            wr_first_n = first;
            first_n    = 1'b0;
          end
        end
        WR_ACK: if (scl_fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) begin
            state_n = WR_BYTE;
            cnt_n   = '0;
          end
        end
        // cnt counts bits already clocked; a fall with cnt==8 hands the line to the master
        RD_BYTE: if (scl_rise) cnt_n = cnt + 4'd1;
        else if (scl_fall) begin
          if (cnt == 4'd8) begin
            state_n = RD_ACK;
            oe_n    = 1'b0;
          end else oe_n = ~cur[3'd7 - cnt[2:0]];
        end
        RD_ACK: if (scl_rise) begin
          if (sda_s) state_n = WAIT_STOP;
          else begin
            state_n = RD_BYTE;
            cnt_n   = '0;
            k_n     = (k >= KW'(RD_BYTES)) ? k : k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aht10_i2c_responder.sv
// tb_aht10_i2c_responder: directed I2C master transfers checked against hand-computed results
module tb_aht10_i2c_responder;
  import aht10_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic [47:0] rd_frame = 48'h1C_6B_A5_35_F2_10;
  logic        sda_line, sda_oe, wr_valid, wr_first, rd_start, bus_stop;
  logic [7:0]  wr_data;
  int          checks = 0, failures = 0;
  int          n_wr = 0, n_rd = 0, n_stop = 0, n_oe = 0;
  logic [8:0]  wr_log[$];

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  aht10_i2c_responder #(.DEV_ADDR(7'h38), .RD_BYTES(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .rd_frame (rd_frame),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_first (wr_first),
    .rd_start (rd_start),
    .bus_stop (bus_stop)
  );

  // event monitor on the inactive edge
  always @(negedge clk) begin
    if (wr_valid) begin
      n_wr++;
      wr_log.push_back({wr_first, wr_data});
    end
    if (rd_start) n_rd++;
    if (bus_stop) n_stop++;
    if (sda_oe) n_oe++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] pop_log();
    return (wr_log.size() > 0) ? wr_log.pop_front() : 9'h1FF;
  endfunction

  task automatic clr();
    n_wr = 0; n_rd = 0; n_stop = 0; n_oe = 0;
    wr_log.delete();
  endtask

  task automatic q();
    repeat (10) @(posedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q(); q();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; q(); scl = 1'b1; q(); b = sda_line; q(); scl = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(nak);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nak);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nak);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       nak;
    int         nwr;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exp_rd[6];
  logic [7:0] b8;
  logic       a, bt;

  initial begin
    tbl[0] = '{8'h70, CMD_TRIG, 1'b0, 1};
    tbl[1] = '{8'h70, CMD_INIT, 1'b0, 1};
    tbl[2] = '{8'h72, 8'h55,    1'b1, 0};
    tbl[3] = '{8'h00, 8'h3C,    1'b1, 0};
    tbl[4] = '{8'h70, CMD_SRST, 1'b0, 1};
    tbl[5] = '{8'hF0, 8'h0F,    1'b1, 0};
    exp_rd = '{8'h1C, 8'h6B, 8'hA5, 8'h35, 8'hF2, 8'h10};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_start", rd_start, 0);
    chk("rst_bus_stop", bus_stop, 0);
    chk("rst_state", dut.state, IDLE);
    rst = 1'b0;
    q();

    // single-byte writes to matching and foreign addresses
    for (int i = 0; i < 6; i++) begin
      clr();
      start_c();
      wbyte(tbl[i].addr, a);
      chk("tbl_addr_ack", a, tbl[i].nak);
      wbyte(tbl[i].data, a);
      chk("tbl_data_ack", a, tbl[i].nak);
      stop_c();
      chk("tbl_nwr", n_wr, tbl[i].nwr);
      if (tbl[i].nwr > 0) chk("tbl_wr", pop_log(), {1'b1, tbl[i].data});
      chk("tbl_no_drive", n_oe == 0, tbl[i].nak);
      chk("tbl_nrd", n_rd, 0);
      chk("tbl_stop", n_stop, 1);
    end

    // trigger command with parameters
    clr();
    start_c();
    wbyte(8'h70, a); chk("w3_addr_ack", a, 0);
    wbyte(8'hAC, a); chk("w3_b0_ack", a, 0);
    wbyte(8'h33, a); chk("w3_b1_ack", a, 0);
    wbyte(8'h00, a); chk("w3_b2_ack", a, 0);
    stop_c();
    chk("w3_nwr", n_wr, 3);
    chk("w3_b0", pop_log(), {1'b1, 8'hAC});
    chk("w3_b1", pop_log(), {1'b0, 8'h33});
    chk("w3_b2", pop_log(), {1'b0, 8'h00});
    chk("w3_stop", n_stop, 1);

    // 6-byte read; frame changes mid-read must not leak into the transfer
    clr();
    start_c();
    wbyte(8'h71, a); chk("rd_addr_ack", a, 0);
    chk("rd_start_cnt", n_rd, 1);
    for (int i = 0; i < 6; i++) begin
      rbyte(b8, i == 5);
      if (i == 0) rd_frame = 48'h00_00_00_00_00_00;
      chk("rd_byte", b8, exp_rd[i]);
    end
    chk("rd_wait_stop", dut.state, WAIT_STOP);
    stop_c();
    chk("rd_idle", dut.state, IDLE);
    chk("rd_nwr", n_wr, 0);

    // read past the frame end saturates to 0xFF
    rd_frame = 48'h1C_6B_A5_35_F2_10;
    clr();
    start_c();
    wbyte(8'h71, a); chk("rd8_addr_ack", a, 0);
    for (int i = 0; i < 8; i++) begin
      rbyte(b8, 1'b0);
      if (i == 5) chk("rd8_b5", b8, 8'h10);
      if (i >= 6) chk("rd8_past_end", b8, 8'hFF);
    end
    stop_c();
    chk("rd8_stop", n_stop, 1);

    // command write then repeated START into a read
    clr();
    start_c();
    wbyte(8'h70, a); chk("rs_waddr_ack", a, 0);
    wbyte(8'hE1, a); chk("rs_cmd_ack", a, 0);
    start_c();
    chk("rs_nwr", n_wr, 1);
    chk("rs_wr", pop_log(), {1'b1, 8'hE1});
    chk("rs_nrd_before", n_rd, 0);
    wbyte(8'h71, a); chk("rs_raddr_ack", a, 0);
    chk("rs_nrd", n_rd, 1);
    rbyte(b8, 1'b1);
    chk("rs_byte0", b8, 8'h1C);
    stop_c();
    chk("rs_stop", n_stop, 1);

    // reset while driving a 0 bit of byte 2 (0xA5, second bit)
    clr();
    start_c();
    wbyte(8'h71, a); chk("rr_addr_ack", a, 0);
    rbyte(b8, 1'b0); chk("rr_b0", b8, 8'h1C);
    rbyte(b8, 1'b0); chk("rr_b1", b8, 8'h6B);
    rbit(bt); chk("rr_bit7", bt, 1);
    chk("rr_driving", sda_oe, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rr_released", sda_oe, 0);
    rst = 1'b0;
    n_oe = 0;
    for (int i = 0; i < 3; i++) rbit(bt);
    chk("rr_ignored", n_oe, 0);
    stop_c();
    clr();
    start_c();
    wbyte(8'h70, a); chk("rr_after_addr_ack", a, 0);
    wbyte(8'hBA, a); chk("rr_after_data_ack", a, 0);
    stop_c();
    chk("rr_after_wr", pop_log(), {1'b1, 8'hBA});
    chk("rr_after_stop", n_stop, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
